// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite compositor.
// Descriptor struct, default geometry, transparent index, ROM base helper.
package sprite_pkg;

   localparam int COORD_W_D  = 11;
   localparam int FRAMES_D   = 4;
   localparam int FRAME_W_D  = $clog2(FRAMES_D);
   localparam int SPR_W_D    = 45;
   localparam int SPR_H_D    = 70;
   localparam int TRANSP_IDX = 63;

   typedef struct packed {
      logic [COORD_W_D-1:0] x;
      logic [COORD_W_D-1:0] y;
      logic                 en;
      logic [FRAME_W_D-1:0] frame;
      logic                 flip;
   } sprite_desc_t;

   // First ROM word of an animation frame.
   function automatic int rom_base(input int frame,
                                   input int w,
                                   input int h);
      return frame * w * h;
   endfunction

endpackage

// File: rtl/sprite_channel.sv
// sprite_channel: one sprite channel. Stage 1 hit test and ROM address,
// stage 2 opaque flag. Ports: pixel in, descriptor, rom_addr/rom_data, opaque.
module sprite_channel
   import sprite_pkg::*;
#(
   parameter int COORD_W = COORD_W_D,
   parameter int COLOR_W = 6,
   parameter int SPR_W   = SPR_W_D,
   parameter int SPR_H   = SPR_H_D,
   parameter int ADDR_W  = 14,
   parameter int TRANSP  = TRANSP_IDX
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] vga_x,
   input  logic [COORD_W-1:0] vga_y,
   input  sprite_desc_t       desc,
   input  logic [COLOR_W-1:0] rom_data,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               opaque
);

   localparam int CW = COORD_W + 1;

   logic [CW-1:0]      vx, vy, sx, sy;
   logic [COORD_W-1:0] lx, ly;
   logic [ADDR_W-1:0]  lxa, base, addr_n;
   logic               hit, hit_d;

   // One extra bit keeps x+SPR_W from wrapping near the screen edge.
   always_comb begin
      vx  = {1'b0, vga_x};
      vy  = {1'b0, vga_y};
      sx  = {1'b0, desc.x};
      sy  = {1'b0, desc.y};
      hit = desc.en
         && vx >= sx && vx < sx + CW'(SPR_W)
         && vy >= sy && vy < sy + CW'(SPR_H);
      lx  = vga_x - desc.x;
      ly  = vga_y - desc.y;
      lxa = ADDR_W'(lx);
      if (desc.flip)
         lxa = ADDR_W'(SPR_W - 1) - lxa;
      base = ADDR_W'(rom_base(int'(desc.frame), SPR_W, SPR_H));
      addr_n = '0;
      if (hit)
         addr_n = base + ADDR_W'(ly) * ADDR_W'(SPR_W) + lxa;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         hit_d    <= 1'b0;
      end else begin
         hit_d <= pix_valid && hit;
         if (pix_valid)
            rom_addr <= addr_n;
      end
   end

   assign opaque = hit_d && (rom_data != COLOR_W'(TRANSP));

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: double-buffered sprite table, per-channel ROM fetch,
// lowest-index-wins priority over bg_color. Optional SPRITE_COLLISION_EN.
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = COORD_W_D,
   parameter int COLOR_W     = 6,
   parameter int SPR_W       = SPR_W_D,
   parameter int SPR_H       = SPR_H_D,
   parameter int FRAMES      = FRAMES_D,
   parameter int ADDR_W      = 14,
   parameter int TRANSP      = TRANSP_IDX
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   input  logic                           frame_start,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
   input  logic [COORD_W-1:0]             cfg_x,
   input  logic [COORD_W-1:0]             cfg_y,
   input  logic                           cfg_enable,
   input  logic [$clog2(FRAMES)-1:0]      cfg_frame,
   input  logic                           cfg_flip,
   input  logic                           pix_valid,
   input  logic [COORD_W-1:0]             vga_x,
   input  logic [COORD_W-1:0]             vga_y,
   input  logic [COLOR_W-1:0]             bg_color,
   output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
   input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
   output logic                           out_valid,
   output logic [COLOR_W-1:0]             out_color,
   output logic                           out_draw,
   output logic [$clog2(NUM_SPRITES)-1:0] out_id
`ifdef SPRITE_COLLISION_EN
   ,
   output logic [NUM_SPRITES-1:0]         coll_flags
`endif
);

   localparam int IDX_W = $clog2(NUM_SPRITES);

   sprite_desc_t           shadow [NUM_SPRITES];
   sprite_desc_t           active [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] opaque;
   logic                   v1, wr, found;
   logic [COLOR_W-1:0]     bg1;
   logic [IDX_W-1:0]       win;

   assign cfg_ready = !frame_start;
   assign wr        = cfg_valid && cfg_ready;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (frame_start)
            for (int i = 0; i < NUM_SPRITES; i++)
               active[i] <= shadow[i];
         if (wr)
            shadow[cfg_idx] <= '{x: cfg_x, y: cfg_y,
                                 en: cfg_enable,
                                 frame: cfg_frame,
                                 flip: cfg_flip};
      end
   end

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
      sprite_channel #(
         .COORD_W(COORD_W), .COLOR_W(COLOR_W),
         .SPR_W(SPR_W), .SPR_H(SPR_H),
         .ADDR_W(ADDR_W), .TRANSP(TRANSP)
      ) u_ch (
         .clk(Clk),
         .rst_n(Reset_n),
         .pix_valid(pix_valid),
         .vga_x(vga_x),
         .vga_y(vga_y),
         .desc(active[i]),
         .rom_data(rom_data[i*COLOR_W +: COLOR_W]),
         .rom_addr(rom_addr[i*ADDR_W +: ADDR_W]),
         .opaque(opaque[i])
      );
   end

   // Scan from the top so the lowest opaque index is left in win.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--)
         if (opaque[i]) begin
            win   = IDX_W'(i);
            found = 1'b1;
         end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v1        <= 1'b0;
         bg1       <= '0;
         out_valid <= 1'b0;
         out_color <= '0;
         out_draw  <= 1'b0;
         out_id    <= '0;
      end else begin
         v1        <= pix_valid;
         out_valid <= v1;
         if (pix_valid)
            bg1 <= bg_color;
         if (v1) begin
            out_draw  <= found;
            out_id    <= win;
            out_color <= found ? rom_data[win*COLOR_W +: COLOR_W] : bg1;
         end
      end
   end

`ifdef SPRITE_COLLISION_EN
   logic                   fs_d;
   logic [NUM_SPRITES-1:0] coll_set;

   always_comb begin
      coll_set = '0;
      for (int i = 1; i < NUM_SPRITES; i++)
         coll_set[i] = v1 && opaque[0] && opaque[i];
   end

   // A set landing on the clear cycle wins over the clear.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fs_d       <= 1'b0;
         coll_flags <= '0;
      end else begin
         fs_d       <= frame_start;
         coll_flags <= (fs_d ? '0 : coll_flags) | coll_set;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed checks of sprite_compositor followed by a
// randomized pixel stream compared against a behavioural model.
module tb_sprite_compositor;

   logic        Clk = 0;
   logic        Reset_n = 0;
   logic        frame_start = 0;
   logic        cfg_valid = 0;
   logic        cfg_ready;
   logic [1:0]  cfg_idx = 0;
   logic [10:0] cfg_x = 0, cfg_y = 0;
   logic        cfg_enable = 0;
   logic [1:0]  cfg_frame = 0;
   logic        cfg_flip = 0;
   logic        pix_valid = 0;
   logic [10:0] vga_x = 0, vga_y = 0;
   logic [5:0]  bg_color = 0;
   logic [55:0] rom_addr;
   logic [23:0] rom_data;
   logic        out_valid;
   logic [5:0]  out_color;
   logic        out_draw;
   logic [1:0]  out_id;
`ifdef SPRITE_COLLISION_EN
   logic [3:0]  coll_flags;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic       use_fn = 0;
   logic [5:0] ovr [4];

   int shx[4], shy[4], shen[4], shfr[4], shfl[4];
   int acx[4], acy[4], acen[4], acfr[4], acfl[4];

   sprite_compositor dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_enable(cfg_enable),
      .cfg_frame(cfg_frame), .cfg_flip(cfg_flip),
      .pix_valid(pix_valid), .vga_x(vga_x), .vga_y(vga_y),
      .bg_color(bg_color), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_color(out_color),
      .out_draw(out_draw), .out_id(out_id)
`ifdef SPRITE_COLLISION_EN
      , .coll_flags(coll_flags)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic int rom_fn(input int c, input int a);
      return ((a * 37 + c * 11) >> 2) % 64;
   endfunction

   always_comb begin
      rom_data = '0;
      for (int c = 0; c < 4; c++)
         rom_data[c*6 +: 6] = use_fn
            ? 6'(rom_fn(c, int'(rom_addr[c*14 +: 14]))) : ovr[c];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic cfg_write(input int i, x, y, en, fr, fl);
      cfg_valid = 1; cfg_idx = 2'(i);
      cfg_x = 11'(x); cfg_y = 11'(y);
      cfg_enable = 1'(en); cfg_frame = 2'(fr); cfg_flip = 1'(fl);
      step();
      cfg_valid = 0;
      shx[i] = x; shy[i] = y; shen[i] = en; shfr[i] = fr; shfl[i] = fl;
   endtask

   task automatic fs_copy();
      for (int i = 0; i < 4; i++) begin
         acx[i] = shx[i]; acy[i] = shy[i]; acen[i] = shen[i];
         acfr[i] = shfr[i]; acfl[i] = shfl[i];
      end
   endtask

   task automatic fs_pulse();
      frame_start = 1;
      step();
      frame_start = 0;
      fs_copy();
   endtask

   task automatic px(input int x, y, bg);
      pix_valid = 1; vga_x = 11'(x); vga_y = 11'(y); bg_color = 6'(bg);
      step();
      pix_valid = 0;
   endtask

   // Reference: geometric containment, frame-major ROM layout,
   // first non-transparent channel in index order wins.
   task automatic model(input int x, y, bg,
                        output int c, d, id, a0);
      int lx, ly, a, v;
      c = bg; d = 0; id = 0; a0 = 0;
      for (int ch = 0; ch < 4; ch++) begin
         if (acen[ch] != 0 && x >= acx[ch] && x < acx[ch] + 45
             && y >= acy[ch] && y < acy[ch] + 70) begin
            lx = x - acx[ch];
            ly = y - acy[ch];
            if (acfl[ch] != 0) lx = 44 - lx;
            a = acfr[ch] * 45 * 70 + ly * 45 + lx;
            if (ch == 0) a0 = a;
            v = rom_fn(ch, a);
            if (v != 63 && d == 0) begin
               d = 1; c = v; id = ch;
            end
         end
      end
   endtask

   initial begin
      int p_v, p_c, p_d, p_id;
      int nc, nd, nid, na0, x, y, bg, r, pv, fs, wi;
      for (int i = 0; i < 4; i++) begin
         ovr[i] = 6'd63;
         shx[i] = 0; shy[i] = 0; shen[i] = 0; shfr[i] = 0; shfl[i] = 0;
      end
      fs_copy();

      step(); step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_color", 32'(out_color), 0);
      chk("rst_out_draw", 32'(out_draw), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_rom_addr", rom_addr[31:0], 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      Reset_n = 1;
      step();

      cfg_write(0, 100, 50, 1, 0, 0);
      fs_pulse();
      ovr[0] = 6'd5;
      px(100, 50, 12);
      chk("origin_addr", 32'(rom_addr[13:0]), 0);
      chk("lat_not_yet", 32'(out_valid), 0);
      step();
      chk("origin_valid", 32'(out_valid), 1);
      chk("origin_color", 32'(out_color), 5);
      chk("origin_draw", 32'(out_draw), 1);
      chk("origin_id", 32'(out_id), 0);
      step();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_hold", 32'(out_color), 5);

      px(144, 119, 12);
      chk("corner_addr", 32'(rom_addr[13:0]), 3149);
      step();
      chk("corner_draw", 32'(out_draw), 1);
      px(145, 50, 12);
      step();
      chk("redge_draw", 32'(out_draw), 0);
      chk("redge_color", 32'(out_color), 12);
      chk("redge_id", 32'(out_id), 0);
      px(100, 120, 33);
      step();
      chk("bedge_draw", 32'(out_draw), 0);
      chk("bedge_color", 32'(out_color), 33);

      cfg_write(2, 100, 50, 1, 0, 0);
      fs_pulse();
      ovr[0] = 6'd63; ovr[2] = 6'd20;
      px(110, 60, 1);
      step();
      chk("transp_color", 32'(out_color), 20);
      chk("transp_id", 32'(out_id), 2);
      ovr[0] = 6'd7;
      px(110, 60, 1);
      step();
      chk("prio_color", 32'(out_color), 7);
      chk("prio_id", 32'(out_id), 0);

      cfg_write(1, 200, 300, 1, 2, 1);
      fs_pulse();
      px(200, 301, 0);
      chk("flip_addr", 32'(rom_addr[27:14]), 6389);
      step();

      frame_start = 1; cfg_valid = 1; cfg_idx = 2'd3;
      cfg_x = 11'd400; cfg_y = 11'd400; cfg_enable = 1;
      cfg_frame = 2'd1; cfg_flip = 0;
      #1;
      chk("fs_ready_low", 32'(cfg_ready), 0);
      step();
      fs_copy();
      frame_start = 0;
      #1;
      chk("fs_ready_high", 32'(cfg_ready), 1);
      step();
      cfg_valid = 0;
      shx[3] = 400; shy[3] = 400; shen[3] = 1; shfr[3] = 1; shfl[3] = 0;
      ovr[3] = 6'd9;
      px(400, 400, 3);
      step();
      chk("shadow_hidden", 32'(out_draw), 0);
      chk("shadow_bg", 32'(out_color), 3);
      fs_pulse();
      px(400, 400, 3);
      chk("swap_addr", 32'(rom_addr[55:42]), 3150);
      step();
      chk("swap_draw", 32'(out_draw), 1);
      chk("swap_color", 32'(out_color), 9);
      chk("swap_id", 32'(out_id), 3);

      cfg_write(1, 2030, 0, 1, 0, 0);
      fs_pulse();
      ovr[1] = 6'd4;
      px(2047, 0, 0);
      chk("clip_addr", 32'(rom_addr[27:14]), 17);
      step();
      chk("clip_draw", 32'(out_draw), 1);
      chk("clip_id", 32'(out_id), 1);
      px(5, 0, 22);
      chk("nowrap_addr", 32'(rom_addr[27:14]), 0);
      step();
      chk("nowrap_draw", 32'(out_draw), 0);
      chk("nowrap_color", 32'(out_color), 22);

`ifdef SPRITE_COLLISION_EN
      cfg_write(1, 100, 50, 1, 0, 0);
      fs_pulse();
      ovr[0] = 6'd5; ovr[1] = 6'd6; ovr[2] = 6'd63;
      px(100, 50, 0);
      step();
      chk("coll_set", 32'(coll_flags), 2);
      fs_pulse();
      chk("coll_hold", 32'(coll_flags), 2);
      step();
      chk("coll_clear", 32'(coll_flags), 0);
`endif

      use_fn = 1;
      for (int i = 0; i < 4; i++)
         cfg_write(i, 80 + int'($urandom % 140), 30 + int'($urandom % 130),
                   int'($urandom % 5 != 0), int'($urandom % 4),
                   int'($urandom % 2));
      fs_pulse();
      step(); step();
      p_v = 0; p_c = 0; p_d = 0; p_id = 0;
      for (int t = 0; t < 500; t++) begin
         pv = int'($urandom % 4 != 0);
         x  = 80 + int'($urandom % 180);
         y  = 30 + int'($urandom % 170);
         bg = int'($urandom % 64);
         pix_valid = 1'(pv); vga_x = 11'(x); vga_y = 11'(y);
         bg_color = 6'(bg);
         model(x, y, bg, nc, nd, nid, na0);
         r = int'($urandom % 100);
         fs = int'(r < 3);
         frame_start = 1'(fs);
         cfg_valid = 0;
         wi = -1;
         if (r >= 3 && r < 10) begin
            wi = int'($urandom % 4);
            cfg_valid = 1; cfg_idx = 2'(wi);
            cfg_x = 11'(80 + int'($urandom % 140));
            cfg_y = 11'(30 + int'($urandom % 130));
            cfg_enable = 1'($urandom % 5 != 0);
            cfg_frame = 2'($urandom % 4);
            cfg_flip = 1'($urandom % 2);
         end
         step();
         chk("rnd_valid", 32'(out_valid), 32'(p_v));
         if (p_v != 0) begin
            chk("rnd_color", 32'(out_color), 32'(p_c));
            chk("rnd_draw", 32'(out_draw), 32'(p_d));
            chk("rnd_id", 32'(out_id), 32'(p_id));
         end
         if (pv != 0)
            chk("rnd_addr0", 32'(rom_addr[13:0]), 32'(na0));
         if (fs != 0) fs_copy();
         if (wi >= 0) begin
            shx[wi] = int'(cfg_x); shy[wi] = int'(cfg_y);
            shen[wi] = int'(cfg_enable); shfr[wi] = int'(cfg_frame);
            shfl[wi] = int'(cfg_flip);
         end
         p_v = pv; p_c = nc; p_d = nd; p_id = nid;
      end
      pix_valid = 0; frame_start = 0; cfg_valid = 0;
      step();
      chk("rnd_last_valid", 32'(out_valid), 32'(p_v));
      if (p_v != 0)
         chk("rnd_last_color", 32'(out_color), 32'(p_c));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
